// File: rtl/spw_rx_pkg.sv
// SpaceWire receive decoder shared definitions: FSM states, control codes,
// N-Char encodings for EOP/EEP and the NULL hunt pattern.
// No logic; no latency; no backpressure.
package spw_rx_pkg;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_PARITY,
      ST_FLAG,
      ST_CTRL,
      ST_DATA
   } rx_state_t;

   // Control codes written c0 first (c0 is the MSB of the 2-bit value).
   localparam logic [1:0] CTRL_FCT = 2'b00;
   localparam logic [1:0] CTRL_EOP = 2'b01;
   localparam logic [1:0] CTRL_EEP = 2'b10;
   localparam logic [1:0] CTRL_ESC = 2'b11;

   // N-Char encodings: bit8 marks a packet marker.
   localparam logic [8:0] NCHAR_EOP = 9'h100;
   localparam logic [8:0] NCHAR_EEP = 9'h101;

   // Hunt window, newest bit at [0]: ESC(F,c0,c1)=1,1,1, FCT P (ignored), FCT(F,c0,c1)=1,0,0.
   localparam logic [6:0] NULL_PATTERN = 7'b1110100;
   localparam logic [6:0] NULL_MASK    = 7'b1110111;

   function automatic logic is_null(input logic [6:0] win);
      return (win & NULL_MASK) == NULL_PATTERN;
   endfunction

endpackage

// File: rtl/rx_spw_bit_recovery.sv
// Data/Strobe bit recovery plus optional link-silence (disconnect) timer.
// Latency: new_bit/bit_val are combinational against the previous registered sample.
// Backpressure: none; every sampled D/S transition is reported immediately.
//
// Ports:
//   pclk_rx, resetn (sync, active-low), enable_rx (low clears history/counter)
//   rx_din, rx_sin : synchronised Data/Strobe samples
//   got_bit        : from decoder, arms the disconnect timer
//   new_bit        : {D,S} differs from the previous sample
//   bit_val        : value of the recovered bit (the Data line)
//   disc_timeout   : the silence counter is reaching DISC_CYCLES this cycle
// Optional: RX_SPW_DISCONNECT_EN enables the disconnect counter; otherwise
// disc_timeout is tied to 0.
module rx_spw_bit_recovery
   import spw_rx_pkg::*;
#(
   parameter int unsigned DISC_CYCLES = 85,
   parameter int unsigned CNT_W       = 8
) (
   input  logic pclk_rx,
   input  logic resetn,
   input  logic enable_rx,
   input  logic rx_din,
   input  logic rx_sin,
   input  logic got_bit,
   output logic new_bit,
   output logic bit_val,
   output logic disc_timeout
);

   logic [1:0] ds_q;

   always_ff @(posedge pclk_rx) begin
      if (!resetn || !enable_rx) begin
         ds_q <= 2'b00;
      end else begin
         ds_q <= {rx_din, rx_sin};
      end
   end

   // DS encoding: exactly one of D/S toggles per bit, so any change is a bit.
   assign new_bit = ({rx_din, rx_sin} != ds_q);
   assign bit_val = rx_din;

`ifdef RX_SPW_DISCONNECT_EN
   localparam logic [CNT_W-1:0] DISC_LIMIT = CNT_W'(DISC_CYCLES);
   localparam logic [CNT_W-1:0] DISC_ARM   = CNT_W'(DISC_CYCLES - 1);

   logic [CNT_W-1:0] disc_cnt_q;

   // Counter is held at zero until the first bit so an idle line at
   // start-up is not mistaken for a disconnect.
   always_ff @(posedge pclk_rx) begin
      if (!resetn || !enable_rx) begin
         disc_cnt_q <= '0;
      end else if (new_bit) begin
         disc_cnt_q <= '0;
      end else if (got_bit && (disc_cnt_q != DISC_LIMIT)) begin
         disc_cnt_q <= disc_cnt_q + CNT_W'(1);
      end
   end

   // Flag on the edge that moves the counter onto DISC_CYCLES, so the error
   // register sets on that same edge.
   assign disc_timeout = got_bit && !new_bit && (disc_cnt_q >= DISC_ARM);
`else
   logic unused_cfg;
   assign unused_cfg   = ^{got_bit, 1'(DISC_CYCLES), 1'(CNT_W)};
   assign disc_timeout = 1'b0;
`endif

endmodule

// File: rtl/rx_spw_decoder.sv
// SpaceWire receive character decoder: NULL hunt, N-Char/FCT/time-code parsing, error detection.
// Latency: strobes and outputs register on the pclk_rx edge that samples a character's last bit.
// Backpressure: none; the link cannot be stalled, downstream must accept every strobe.
//
// Ports:
//   pclk_rx, resetn (sync, active-low), enable_rx (low = HUNT, errors cleared)
//   rx_din, rx_sin       : synchronised Data/Strobe lines
//   rx_data_o[8:0]       : N-Char, bit8=1 marks EOP (0x00) / EEP (0x01)
//   rx_data_valid        : one-cycle strobe for rx_data_o
//   timecode_o[7:0]      : last time-code, tick_out strobes on update
//   got_null, got_fct    : one-cycle strobes to the link-state FSM
//   got_bit              : sticky, a bit has been seen since enable
//   parity_error, escape_error, disconnect_error : sticky errors
// Optional: RX_SPW_DISCONNECT_EN enables disconnect detection (DISC_CYCLES
// silent cycles after the first bit); otherwise disconnect_error stays 0.
module rx_spw_decoder
   import spw_rx_pkg::*;
#(
   parameter int unsigned DISC_CYCLES = 85,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       pclk_rx,
   input  logic       resetn,
   input  logic       enable_rx,
   input  logic       rx_din,
   input  logic       rx_sin,
   output logic [8:0] rx_data_o,
   output logic       rx_data_valid,
   output logic [7:0] timecode_o,
   output logic       tick_out,
   output logic       got_null,
   output logic       got_fct,
   output logic       got_bit,
   output logic       parity_error,
   output logic       escape_error,
   output logic       disconnect_error
);

   logic new_bit;
   logic bit_val;
   logic disc_timeout;

   rx_spw_bit_recovery #(
      .DISC_CYCLES (DISC_CYCLES),
      .CNT_W       (CNT_W)
   ) u_bit_rec (
      .pclk_rx      (pclk_rx),
      .resetn       (resetn),
      .enable_rx    (enable_rx),
      .rx_din       (rx_din),
      .rx_sin       (rx_sin),
      .got_bit      (got_bit),
      .new_bit      (new_bit),
      .bit_val      (bit_val),
      .disc_timeout (disc_timeout)
   );

   rx_state_t  state_q, state_n;
   logic [6:0] win_q, win_n;          // hunt window, newest bit at [0]
   logic [6:0] sr_q, sr_n;            // character shift register, LSB first
   logic [2:0] cnt_q, cnt_n;          // bits received in CTRL/DATA
   logic       p_q, p_n;              // parity bit of current character
   logic       par_acc_q, par_acc_n;  // XOR of previous character's payload bits
   logic       esc_q, esc_n;          // ESC received, awaiting its partner

   logic [8:0] data_n;
   logic       data_vld_n;
   logic [7:0] timecode_n;
   logic       tick_n;
   logic       null_n;
   logic       fct_n;
   logic       got_bit_n;
   logic       par_err_n;
   logic       esc_err_n;
   logic       disc_err_n;

   logic [6:0] win_shift;
   logic [1:0] ctrl_code;
   logic [7:0] data_byte;

   assign win_shift = {win_q[5:0], bit_val};
   // Decode uses the incoming last bit directly so outputs register on its edge.
   assign ctrl_code = {sr_q[6], bit_val};
   assign data_byte = {bit_val, sr_q};

   always_comb begin
      state_n    = state_q;
      win_n      = win_q;
      sr_n       = sr_q;
      cnt_n      = cnt_q;
      p_n        = p_q;
      par_acc_n  = par_acc_q;
      esc_n      = esc_q;
      data_n     = rx_data_o;
      data_vld_n = 1'b0;
      timecode_n = timecode_o;
      tick_n     = 1'b0;
      null_n     = 1'b0;
      fct_n      = 1'b0;
      got_bit_n  = got_bit | new_bit;
      par_err_n  = parity_error;
      esc_err_n  = escape_error;
      disc_err_n = disconnect_error;

      if (disc_timeout) begin
         disc_err_n = 1'b1;
         state_n    = ST_HUNT;
         win_n      = '0;
         esc_n      = 1'b0;
      end else if (new_bit) begin
         unique case (state_q)
            ST_HUNT: begin
               win_n = win_shift;
               if (is_null(win_shift)) begin
                  null_n    = 1'b1;
                  state_n   = ST_PARITY;
                  win_n     = '0;
                  esc_n     = 1'b0;
                  par_acc_n = 1'b0;   // the matched FCT carried payload 00
               end
            end
            ST_PARITY: begin
               p_n     = bit_val;
               state_n = ST_FLAG;
            end
            ST_FLAG: begin
               if (par_acc_q ^ p_q ^ bit_val) begin
                  cnt_n   = 3'd0;
                  state_n = bit_val ? ST_CTRL : ST_DATA;
               end else begin
                  par_err_n = 1'b1;
                  state_n   = ST_HUNT;
                  win_n     = '0;
                  esc_n     = 1'b0;
               end
            end
            ST_CTRL: begin
               sr_n  = {bit_val, sr_q[6:1]};
               cnt_n = cnt_q + 3'd1;
               if (cnt_q == 3'd1) begin
                  par_acc_n = ^ctrl_code;
                  state_n   = ST_PARITY;
                  esc_n     = 1'b0;
                  unique case (ctrl_code)
                     CTRL_FCT: begin
                        if (esc_q) null_n = 1'b1;
                        else       fct_n  = 1'b1;
                     end
                     CTRL_EOP, CTRL_EEP: begin
                        if (esc_q) begin
                           esc_err_n = 1'b1;
                           state_n   = ST_HUNT;
                           win_n     = '0;
                        end else begin
                           data_n     = (ctrl_code == CTRL_EOP) ? NCHAR_EOP : NCHAR_EEP;
                           data_vld_n = 1'b1;
                        end
                     end
                     CTRL_ESC: begin
                        if (esc_q) begin
                           esc_err_n = 1'b1;
                           state_n   = ST_HUNT;
                           win_n     = '0;
                        end else begin
                           esc_n = 1'b1;
                        end
                     end
                  endcase
               end
            end
            ST_DATA: begin
               sr_n  = {bit_val, sr_q[6:1]};
               cnt_n = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  par_acc_n = ^data_byte;
                  state_n   = ST_PARITY;
                  esc_n     = 1'b0;
                  if (esc_q) begin
                     timecode_n = data_byte;
                     tick_n     = 1'b1;
                  end else begin
                     data_n     = {1'b0, data_byte};
                     data_vld_n = 1'b1;
                  end
               end
            end
            default: begin
               state_n = ST_HUNT;
               win_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge pclk_rx) begin
      if (!resetn || !enable_rx) begin
         state_q          <= ST_HUNT;
         win_q            <= '0;
         sr_q             <= '0;
         cnt_q            <= '0;
         p_q              <= 1'b0;
         par_acc_q        <= 1'b0;
         esc_q            <= 1'b0;
         rx_data_o        <= '0;
         rx_data_valid    <= 1'b0;
         timecode_o       <= '0;
         tick_out         <= 1'b0;
         got_null         <= 1'b0;
         got_fct          <= 1'b0;
         got_bit          <= 1'b0;
         parity_error     <= 1'b0;
         escape_error     <= 1'b0;
         disconnect_error <= 1'b0;
      end else begin
         state_q          <= state_n;
         win_q            <= win_n;
         sr_q             <= sr_n;
         cnt_q            <= cnt_n;
         p_q              <= p_n;
         par_acc_q        <= par_acc_n;
         esc_q            <= esc_n;
         rx_data_o        <= data_n;
         rx_data_valid    <= data_vld_n;
         timecode_o       <= timecode_n;
         tick_out         <= tick_n;
         got_null         <= null_n;
         got_fct          <= fct_n;
         got_bit          <= got_bit_n;
         parity_error     <= par_err_n;
         escape_error     <= esc_err_n;
         disconnect_error <= disc_err_n;
      end
   end

endmodule
